mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Memory-stage data-access engine for the pipelined MIPS core. It consumes the M-stage memory controls the decoder pipeline produces (`memtoregM`, `memwriteM`, `readtypeM`) plus the address and store data. It runs one request/acknowledge transaction on the external data-memory bus, with byte-lane steering and load sign/zero extension. It holds the pipeline with `stallM` until the access finishes.

## Interface
Parameters:
- `TIMEOUT`, default 255: maximum cycles `mem_req` is held without `mem_ack` before the access is aborted with a bus error. Legal range is 1 to 255.

Ports:
- `clk`  in  1  system clock; everything is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `memtoregM`  in  1  the instruction in M is a load.
- `memwriteM`  in  2  store type: 00 none, 01 sw, 10 sh, 11 sb.
- `readtypeM`  in  3  load type: 000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu; 101–111 are treated as lw.
- `aluoutM`  in  32  byte address.
- `writedataM`  in  32  store data, right-justified.
- `readdataM`  out  32  aligned and extended load result.
- `stallM`  out  1  holds F/D/E/M; the W stage receives a bubble.
- `misalignM`  out  1  address misaligned for the access size.
- `buserrM`  out  1  access aborted by timeout.
- `mem_req`  out  1  bus request, held until acknowledged.
- `mem_we`  out  1  1 for a write, 0 for a read.
- `mem_addr`  out  32  word address, `{aluoutM[31:2],2'b00}`.
- `mem_be`  out  4  byte enables; bit n covers byte lane n (little-endian).
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_rdata`  in  32  read data; valid only while `mem_ack` is high.
- `mem_ack`  in  1  completes the transaction at the edge where `mem_req && mem_ack`.

## Operation
- An access is pending when `memtoregM || memwriteM!=0`. If `memtoregM` and `memwriteM!=0` are both set, the store wins.
- Misalignment is combinational:
  - word access with `aluoutM[1:0]!=0` is misaligned;
  - half access with `aluoutM[0]!=0` is misaligned;
  - on a misaligned access: `misalignM=1`, no bus transaction, `stallM=0`, `readdataM=0`.
- FSM states IDLE, BUSY, DONE.
  - IDLE: a pending, aligned access makes `stallM=1`. At the next edge the FSM moves to BUSY, registers `mem_req=1`, the `mem_we` / `mem_addr` / `mem_be` / `mem_wdata` values and the access type, and clears the timeout counter.
  - BUSY: `stallM=1`. On `mem_ack`, capture `mem_rdata` and go to DONE, with `mem_req=0` registered from that edge. If the counter reaches `TIMEOUT` first, set `buserr` and go to DONE with `mem_req=0`.
  - DONE: `stallM=0`. `readdataM` comes from the captured data; `buserrM` is valid for this cycle only. The next edge returns the FSM to IDLE unconditionally, so the next M instruction is evaluated fresh.
- Byte enables:
  - sw: `mem_be=1111`.
  - sh: `mem_be=0011<<(2*aluoutM[1])`.
  - sb: `mem_be=0001<<aluoutM[1:0]`.
- Store data: sh replicates `wd[15:0]` twice; sb replicates `wd[7:0]` four times.
- Loads select the lane from the registered `addr[1:0]`:
  - lb/lh sign-extend;
  - lbu/lhu zero-extend;
  - lw passes the word through.
- `readdataM` is 0 except in DONE. After a bus error, `readdataM=0`.

## Timing
- Reset values: state IDLE; `mem_req` / `mem_we` / `buserrM` / `misalignM` all 0; `mem_be`, `mem_addr`, `mem_wdata` and `readdataM` all 0.
- `stallM` is combinational from state and inputs, and is 0 during reset.
- Zero-wait memory: the access is in M at cycle 0. `mem_req` is high in cycle 1, `mem_ack` arrives in cycle 1, and DONE is cycle 2. That gives 2 stall cycles and `readdataM` valid in cycle 2.
- Each extra wait cycle before `mem_ack` adds exactly one stall cycle.
- A timeout aborts after exactly `TIMEOUT` BUSY cycles.
- `mem_ack` outside BUSY is ignored.
- Back-to-back accesses: DONE→IDLE costs no extra cycle beyond the 2-cycle minimum.
- Reset mid-BUSY: the FSM returns to IDLE immediately and `mem_req` drops at that edge. The system must also reset memory.

## Structure
- Package `mem_pkg` holds:
  - the `memwrite_t` enum (NONE/SW/SH/SB);
  - the `readtype_t` enum (LW/LH/LHU/LB/LBU);
  - the `mstate_t` enum (IDLE/BUSY/DONE);
  - the constant `TO_W=8`.
- Sub-module `load_align` is combinational and computes `readdataM` from the word, `addr[1:0]` and `readtype`.

## Test plan
- lb at `0x1003`, memory word `0x80FF7F01`, zero-wait memory → `readdataM=0xFFFFFF80` in cycle 2; `stallM` high in cycles 0–1.
- sh at `0x2002` with `writedataM=0x1234ABCD` → `mem_be=1100`, `mem_wdata=0xABCDABCD`, `mem_we=1`, `mem_addr=0x2000`.
- lhu at `0x3000`, `mem_ack` delayed 3 cycles, word `0x0000F00D` → 5 stall cycles; `readdataM=0x0000F00D`.
- lw at `0x4002` → `misalignM=1`, `mem_req` stays 0, `stallM=0`.
- sw with `TIMEOUT=4` and no `mem_ack` → `buserrM` pulses high for 1 cycle after 4 BUSY cycles; `mem_req` low afterwards.
- `reset` asserted in the second BUSY cycle → next cycle state IDLE, all outputs 0.

Source files
------------

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and constants for the memory-stage access engine
package mem_pkg;

    typedef enum logic [1:0] {
        NONE = 2'b00,
        SW   = 2'b01,
        SH   = 2'b10,
        SB   = 2'b11
    } memwrite_t;

    typedef enum logic [2:0] {
        LW  = 3'b000,
        LH  = 3'b001,
        LHU = 3'b010,
        LB  = 3'b011,
        LBU = 3'b100
    } readtype_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } mstate_t;

    localparam int TO_W = 8;

endpackage

// File: rtl/mem_access_unit_load_align.sv
// rtl/mem_access_unit_load_align.sv - lane select and sign/zero extension of a loaded word
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  readtype_t   rtype,
    output logic [31:0] data
);

    logic [31:0] lane;

    // Bring the addressed byte/half down to bit 0 before extending.
    assign lane = word >> {addr_lo, 3'b000};

    always_comb begin
        data = word;
        case (rtype)
            LH:      data = {{16{lane[15]}}, lane[15:0]};
            LHU:     data = {16'h0000, lane[15:0]};
            LB:      data = {{24{lane[7]}}, lane[7:0]};
            LBU:     data = {24'h000000, lane[7:0]};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - M-stage data-memory bus engine with stall, misalign and timeout
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memtoregM,
    input  logic [1:0]  memwriteM,
    input  logic [2:0]  readtypeM,
    input  logic [31:0] aluoutM,
    input  logic [31:0] writedataM,
    output logic [31:0] readdataM,
    output logic        stallM,
    output logic        misalignM,
    output logic        buserrM,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    mstate_t         state;
    logic [TO_W-1:0] cnt;
    logic [31:0]     rdata_q;
    readtype_t       rtype_q;
    logic [1:0]      addr_lo_q;
    logic            load_q;
    logic            buserr_q;

    logic            is_store;
    logic            pending;
    logic            mis;
    logic            go;
    logic [3:0]      be_n;
    logic [31:0]     wd_n;
    readtype_t       rtype_n;
    logic [31:0]     aligned;

    assign is_store = (memwriteM != 2'b00);
    assign pending  = memtoregM || is_store;
    assign rtype_n  = (readtypeM > 3'd4) ? LW : readtype_t'(readtypeM);

    // A store takes precedence over a load when both controls are set.
    always_comb begin
        mis  = 1'b0;
        be_n = 4'b1111;
        wd_n = 32'h0;
        if (is_store) begin
            case (memwriteM)
                SH: begin
                    mis  = aluoutM[0];
                    be_n = 4'b0011 << {aluoutM[1], 1'b0};
                    wd_n = {2{writedataM[15:0]}};
                end
                SB: begin
                    be_n = 4'b0001 << aluoutM[1:0];
                    wd_n = {4{writedataM[7:0]}};
                end
                default: begin
                    mis  = (aluoutM[1:0] != 2'b00);
                    wd_n = writedataM;
                end
            endcase
        end else begin
            case (rtype_n)
                LH, LHU: begin
                    mis  = aluoutM[0];
                    be_n = 4'b0011 << {aluoutM[1], 1'b0};
                end
                LB, LBU: be_n = 4'b0001 << aluoutM[1:0];
                default: mis = (aluoutM[1:0] != 2'b00);
            endcase
        end
    end

    assign go = pending && !mis;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'h0;
            mem_be    <= 4'h0;
            mem_wdata <= 32'h0;
            rdata_q   <= 32'h0;
            rtype_q   <= LW;
            addr_lo_q <= 2'b00;
            load_q    <= 1'b0;
            buserr_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (go) begin
                        state     <= BUSY;
                        cnt       <= '0;
                        mem_req   <= 1'b1;
                        mem_we    <= is_store;
                        mem_addr  <= {aluoutM[31:2], 2'b00};
                        mem_be    <= be_n;
                        mem_wdata <= wd_n;
                        rtype_q   <= rtype_n;
                        addr_lo_q <= aluoutM[1:0];
                        load_q    <= !is_store;
                    end
                end
                BUSY: begin
                    // An acknowledge in the final allowed cycle still completes normally.
                    if (mem_ack) begin
                        rdata_q <= mem_rdata;
                        mem_req <= 1'b0;
                        state   <= DONE;
                    end else if (cnt == TO_LAST) begin
                        buserr_q <= 1'b1;
                        mem_req  <= 1'b0;
                        state    <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    buserr_q <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    load_align u_load_align (
        .word    (rdata_q),
        .addr_lo (addr_lo_q),
        .rtype   (rtype_q),
        .data    (aligned)
    );

    assign stallM    = !reset && ((state == IDLE && go) || state == BUSY);
    assign misalignM = !reset && state == IDLE && pending && mis;
    assign buserrM   = buserr_q;
    assign readdataM = (!reset && state == DONE && load_q && !buserr_q) ? aligned : 32'h0;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - randomized self-checking bench for mem_access_unit
module tb_mem_access_unit;

    localparam int TIMEOUT = 4;

    logic        clk;
    logic        reset;
    logic        memtoregM;
    logic [1:0]  memwriteM;
    logic [2:0]  readtypeM;
    logic [31:0] aluoutM;
    logic [31:0] writedataM;
    logic [31:0] readdataM;
    logic        stallM;
    logic        misalignM;
    logic        buserrM;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    mem_access_unit #(.TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .reset      (reset),
        .memtoregM  (memtoregM),
        .memwriteM  (memwriteM),
        .readtypeM  (readtypeM),
        .aluoutM    (aluoutM),
        .writedataM (writedataM),
        .readdataM  (readdataM),
        .stallM     (stallM),
        .misalignM  (misalignM),
        .buserrM    (buserrM),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    logic        chk;
    logic        exp_stall, exp_mis, exp_berr, exp_req, exp_we, exp_store, rd_chk;
    logic [31:0] exp_addr, exp_wd, exp_rd;
    logic [3:0]  exp_be;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        check32(name, {31'b0, act}, {31'b0, exp});
    endtask

    // Reference rules written from the access semantics.
    function automatic logic f_mis(input logic mtr, input logic [1:0] mw, input logic [2:0] rt,
                                   input logic [1:0] a);
        int sz;
        if (mw != 2'd0) sz = (mw == 2'd1) ? 4 : (mw == 2'd2) ? 2 : 1;
        else if (rt == 3'd1 || rt == 3'd2) sz = 2;
        else if (rt == 3'd3 || rt == 3'd4) sz = 1;
        else sz = 4;
        return (mtr || mw != 2'd0) && ((int'(a) % sz) != 0);
    endfunction

    function automatic logic [3:0] f_be(input logic [1:0] mw, input logic [1:0] a);
        if (mw == 2'd1) return 4'hF;
        if (mw == 2'd2) return a[1] ? 4'b1100 : 4'b0011;
        return 4'(1 << int'(a));
    endfunction

    function automatic logic [31:0] f_wd(input logic [1:0] mw, input logic [31:0] wd);
        if (mw == 2'd2) return {wd[15:0], wd[15:0]};
        if (mw == 2'd3) return {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
        return wd;
    endfunction

    function automatic logic [31:0] f_ext(input logic [31:0] word, input logic [1:0] a,
                                          input logic [2:0] rt);
        logic [31:0] s;
        s = word >> (8 * int'(a));
        case (rt)
            3'd1:    return 32'($signed(s[15:0]));
            3'd2:    return 32'(s[15:0]);
            3'd3:    return 32'($signed(s[7:0]));
            3'd4:    return 32'(s[7:0]);
            default: return word;
        endcase
    endfunction

    always @(negedge clk) begin
        if (chk) begin
            check1("stallM", stallM, exp_stall);
            check1("misalignM", misalignM, exp_mis);
            check1("buserrM", buserrM, exp_berr);
            check1("mem_req", mem_req, exp_req);
            if (rd_chk) check32("readdataM", readdataM, exp_rd);
            if (exp_req) begin
                check1("mem_we", mem_we, exp_we);
                check32("mem_addr", mem_addr, exp_addr);
                if (exp_store) begin
                    check32("mem_be", {28'b0, mem_be}, {28'b0, exp_be});
                    check32("mem_wdata", mem_wdata, exp_wd);
                end
            end
        end
    end

    // lat: wait cycles before ack (ack in BUSY cycle lat+1), negative means never ack.
    task automatic run_txn(input logic mtr, input logic [1:0] mw, input logic [2:0] rt,
                           input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] word,
                           input int lat, output int nstall, output logic [31:0] rd_out,
                           output logic [3:0] be_out, output logic [31:0] wd_out);
        logic store, active, to, ack_now;
        int last_busy, d;
        store     = (mw != 2'd0);
        active    = (mtr || store) && !f_mis(mtr, mw, rt, addr[1:0]);
        to        = (lat < 0) || (lat + 1 > TIMEOUT);
        last_busy = to ? TIMEOUT : lat + 1;
        d         = active ? last_busy + 1 : 0;
        nstall = 0; rd_out = 0; be_out = 0; wd_out = 0;
        for (int k = 0; k <= d; k++) begin
            memtoregM  = mtr;
            memwriteM  = mw;
            readtypeM  = rt;
            aluoutM    = addr;
            writedataM = wd;
            ack_now    = active && !to && (k == lat + 1);
            mem_ack    = ack_now ? 1'b1 : ((k == 0 || k == d) ? 1'($urandom_range(0, 1)) : 1'b0);
            mem_rdata  = ack_now ? word : $urandom;
            exp_stall  = active && (k <= last_busy);
            exp_mis    = (mtr || store) && !active;
            exp_req    = active && k >= 1 && k <= last_busy;
            exp_berr   = active && to && k == d;
            exp_we     = store;
            exp_addr   = {addr[31:2], 2'b00};
            exp_be     = f_be(mw, addr[1:0]);
            exp_wd     = f_wd(mw, wd);
            exp_store  = store;
            rd_chk     = !(active && store && k == d);
            exp_rd     = (active && !store && !to && k == d) ? f_ext(word, addr[1:0], rt) : 32'h0;
            @(negedge clk);
            if (stallM) nstall++;
            if (k == d) rd_out = readdataM;
            if (k == 1) begin
                be_out = mem_be;
                wd_out = mem_wdata;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_idle_expect();
        exp_stall = 0; exp_mis = 0; exp_berr = 0; exp_req = 0; exp_we = 0;
        exp_store = 0; rd_chk = 1; exp_rd = 0; exp_addr = 0; exp_be = 0; exp_wd = 0;
    endtask

    int          ns;
    logic [31:0] rd, wdo;
    logic [3:0]  beo;

    initial begin
        chk = 0;
        set_idle_expect();
        reset = 1; memtoregM = 0; memwriteM = 2'd1; readtypeM = 0;
        aluoutM = 32'h10; writedataM = 32'hDEADBEEF; mem_ack = 1; mem_rdata = 32'h0;
        @(posedge clk); #1;
        chk = 1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check32("reset_be", {28'b0, mem_be}, 32'h0);
            check32("reset_addr", mem_addr, 32'h0);
            check32("reset_wdata", mem_wdata, 32'h0);
            check1("reset_we", mem_we, 1'b0);
            @(posedge clk); #1;
        end
        reset = 0;

        // Pin the reference rules against hand-computed values.
        check32("pin_lb_ext", f_ext(32'h80FF7F01, 2'd3, 3'd3), 32'hFFFFFF80);
        check32("pin_sh_be", {28'b0, f_be(2'd2, 2'd2)}, 32'h0000000C);
        check32("pin_sh_wd", f_wd(2'd2, 32'h1234ABCD), 32'hABCDABCD);

        run_txn(1, 2'd0, 3'd3, 32'h1003, 32'h0, 32'h80FF7F01, 0, ns, rd, beo, wdo);
        check32("lb_stalls", ns, 2);
        check32("lb_data", rd, 32'hFFFFFF80);

        run_txn(0, 2'd2, 3'd0, 32'h2002, 32'h1234ABCD, 32'h0, 0, ns, rd, beo, wdo);
        check32("sh_be", {28'b0, beo}, 32'h0000000C);
        check32("sh_wdata", wdo, 32'hABCDABCD);

        run_txn(1, 2'd0, 3'd2, 32'h3000, 32'h0, 32'h0000F00D, 3, ns, rd, beo, wdo);
        check32("lhu_stalls", ns, 5);
        check32("lhu_data", rd, 32'h0000F00D);

        run_txn(1, 2'd0, 3'd0, 32'h4002, 32'h0, 32'h0, 0, ns, rd, beo, wdo);
        check32("lw_mis_stalls", ns, 0);

        run_txn(0, 2'd1, 3'd0, 32'h5000, 32'hCAFEF00D, 32'h0, -1, ns, rd, beo, wdo);
        check32("timeout_stalls", ns, TIMEOUT + 1);

        // Reset in the second BUSY cycle of a store.
        memtoregM = 0; memwriteM = 2'd1; readtypeM = 0; aluoutM = 32'h6004;
        writedataM = 32'h11223344; mem_ack = 0;
        set_idle_expect();
        exp_stall = 1;
        @(posedge clk); #1;
        exp_req = 1; exp_we = 1; exp_addr = 32'h6004; exp_store = 1;
        exp_be = 4'hF; exp_wd = 32'h11223344;
        @(posedge clk); #1;
        chk = 0;
        reset = 1;
        @(negedge clk);
        check1("midrst_stall", stallM, 1'b0);
        check32("midrst_rd", readdataM, 32'h0);
        @(posedge clk); #1;
        reset = 0; memwriteM = 0; aluoutM = 0; writedataM = 0;
        set_idle_expect();
        chk = 1;
        @(negedge clk);
        check32("midrst_be", {28'b0, mem_be}, 32'h0);
        check32("midrst_addr", mem_addr, 32'h0);
        check32("midrst_wdata", mem_wdata, 32'h0);
        check1("midrst_we", mem_we, 1'b0);
        @(posedge clk); #1;

        for (int t = 0; t < 300; t++) begin
            logic        mtr;
            logic [1:0]  mw;
            int          lat;
            int          r;
            mtr = 1'($urandom_range(0, 1));
            mw  = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
            r   = $urandom_range(0, 7);
            lat = (r == 0) ? -1 : $urandom_range(0, 4);
            run_txn(mtr, mw, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom, lat,
                    ns, rd, beo, wdo);
        end

        chk = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
